image_frame_loader: RTL and testbench

Collects one binary image frame from the JTAG mailbox, arriving as 14-word chunks with a NEXT/FINISH handshake, into an internal frame buffer. Once the final chunk lands, it streams the frame to the spiking-network core as fixed-width pixel beats under valid/ready flow control, framed by a start pulse and a last flag. It sits between the JTAG data registers and `run_network` and replaces ad-hoc capture logic in the top level.

---
 rtl/image_frame_loader.sv | 122 ++++++++++++
 tb/tb_image_frame_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_loader.sv
// Captures JTAG mailbox chunks into a frame buffer, then streams the frame
// to the network core as PIX_W-bit beats under valid/ready flow control.
module image_frame_loader #(
   parameter int WORD_W     = 32,
   parameter int WORDS      = 14,
   parameter int FRAME_BITS = 800,
   parameter int PIX_W      = 7
) (
   input  logic                    iCLK,
   input  logic                    iRESETn,
   input  logic [WORDS*WORD_W-1:0] iDATA,
   input  logic                    iNEXT,
   input  logic                    iFINISH,
   input  logic                    iREADY,
   output logic [PIX_W-1:0]        oPIXELS,
   output logic                    oPIX_VALID,
   output logic                    oLAST,
   output logic                    oSTART,
   output logic                    oBUSY,
   output logic                    oERR
);

   localparam int CHUNK_W = WORDS * WORD_W;
   localparam int NB      = (FRAME_BITS + PIX_W - 1) / PIX_W;
   localparam int WP_W    = $clog2(FRAME_BITS + 1);
   localparam int B_W     = $clog2(NB);
   localparam int BO_W    = $clog2(FRAME_BITS + PIX_W);

   typedef enum logic [1:0] {COLLECT, START, STREAM} state_t;

   state_t                  state;
   state_t                  stateNext;
   logic                    nextQ;
   logic                    nextRise;
   logic [WP_W-1:0]         wp;
   logic [B_W-1:0]          beat;
   logic [FRAME_BITS-1:0]   frameBuf;
   logic                    errQ;
   logic                    chunkFits;
   logic                    lastBeat;
   logic [FRAME_BITS-1:0]   shData;
   logic [FRAME_BITS-1:0]   shMask;
   logic [FRAME_BITS-1:0]   bufWritten;
   logic [FRAME_BITS+PIX_W-1:0] padded;
   logic [BO_W-1:0]         beatOff;

   assign nextRise  = iNEXT & ~nextQ;
   assign chunkFits = (int'(wp) + CHUNK_W) <= FRAME_BITS;
   assign lastBeat  = (int'(beat) == NB - 1);

   // Shifting in FRAME_BITS width drops whatever lands past the buffer end,
   // which is exactly the truncation the final (short) chunk needs.
   assign shData     = FRAME_BITS'(iDATA) << wp;
   assign shMask     = FRAME_BITS'({CHUNK_W{1'b1}}) << wp;
   assign bufWritten = (frameBuf & ~shMask) | shData;

   // Zero padding above the buffer supplies the pad bits of the last beat.
   assign padded  = {{PIX_W{1'b0}}, frameBuf};
   assign beatOff = BO_W'(int'(beat) * PIX_W);

   assign oPIX_VALID = (state == STREAM);
   assign oBUSY      = (state == STREAM);
   assign oSTART     = (state == START);
   assign oLAST      = (state == STREAM) && lastBeat;
   assign oPIXELS    = (state == STREAM) ? padded[beatOff +: PIX_W] : '0;
   assign oERR       = errQ;

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state <= COLLECT;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         COLLECT: if (nextRise && iFINISH) stateNext = START;
         START:   stateNext = STREAM;
         STREAM:  if (iREADY && lastBeat) stateNext = COLLECT;
         default: stateNext = COLLECT;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         nextQ    <= 1'b0;
         wp       <= '0;
         beat     <= '0;
         frameBuf <= '0;
         errQ     <= 1'b0;
      end else begin
         nextQ <= iNEXT;
         case (state)
            COLLECT: begin
               if (nextRise) begin
                  if (iFINISH) begin
                     frameBuf <= bufWritten;
                     wp       <= '0;
                  end else if (chunkFits) begin
                     frameBuf <= bufWritten;
                     wp       <= wp + WP_W'(CHUNK_W);
                  end else begin
                     errQ <= 1'b1;
                  end
               end
            end
            START: begin
               beat <= '0;
               if (nextRise) errQ <= 1'b1;
            end
            STREAM: begin
               if (nextRise) errQ <= 1'b1;
               if (iREADY && !lastBeat) beat <= beat + B_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_image_frame_loader.sv
// Randomized bench for image_frame_loader against a bit-array frame model.
module tb_image_frame_loader;

   localparam int WORD_W     = 32;
   localparam int WORDS      = 14;
   localparam int FRAME_BITS = 800;
   localparam int PIX_W      = 7;
   localparam int CHUNK_W    = WORDS * WORD_W;
   localparam int NB         = 115;

   logic               iCLK = 1'b0;
   logic               iRESETn = 1'b0;
   logic [CHUNK_W-1:0] iDATA = '0;
   logic               iNEXT = 1'b0;
   logic               iFINISH = 1'b0;
   logic               iREADY = 1'b0;
   logic [PIX_W-1:0]   oPIXELS;
   logic               oPIX_VALID;
   logic               oLAST;
   logic               oSTART;
   logic               oBUSY;
   logic               oERR;

   image_frame_loader #(
      .WORD_W(WORD_W), .WORDS(WORDS), .FRAME_BITS(FRAME_BITS), .PIX_W(PIX_W)
   ) dut (
      .iCLK(iCLK), .iRESETn(iRESETn), .iDATA(iDATA), .iNEXT(iNEXT),
      .iFINISH(iFINISH), .iREADY(iREADY), .oPIXELS(oPIXELS),
      .oPIX_VALID(oPIX_VALID), .oLAST(oLAST), .oSTART(oSTART),
      .oBUSY(oBUSY), .oERR(oERR)
   );

   always #4 iCLK = ~iCLK;

   int nCompared = 0;
   int nMismatched = 0;

   bit refBuf [FRAME_BITS];
   int refWp;
   bit refErr;
   logic [NB*PIX_W-1:0] streamBits;
   logic [CHUNK_W-1:0]  c0, c1;

   task automatic checkEq(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < FRAME_BITS; i++) refBuf[i] = 1'b0;
      refWp  = 0;
      refErr = 1'b0;
   endtask

   task automatic modelChunk(input logic [CHUNK_W-1:0] data, input bit fin);
      if (!fin) begin
         if (refWp + CHUNK_W > FRAME_BITS) refErr = 1'b1;
         else begin
            for (int i = 0; i < CHUNK_W; i++) refBuf[refWp + i] = data[i];
            refWp += CHUNK_W;
         end
      end else begin
         for (int i = 0; i < CHUNK_W && refWp + i < FRAME_BITS; i++) refBuf[refWp + i] = data[i];
         refWp = 0;
      end
   endtask

   function automatic logic [PIX_W-1:0] expPix(input int b);
      logic [PIX_W-1:0] p;
      for (int j = 0; j < PIX_W; j++) begin
         int idx;
         idx = b * PIX_W + j;
         p[j] = (idx < FRAME_BITS) ? refBuf[idx] : 1'b0;
      end
      return p;
   endfunction

   function automatic logic [CHUNK_W-1:0] randChunk();
      logic [CHUNK_W-1:0] r;
      for (int i = 0; i < WORDS; i++) r[i*WORD_W +: WORD_W] = $urandom;
      return r;
   endfunction

   task automatic applyReset();
      @(negedge iCLK);
      iRESETn = 1'b0;
      iNEXT   = 1'b0;
      iREADY  = 1'b0;
      modelReset();
      repeat (2) @(negedge iCLK);
      iRESETn = 1'b1;
   endtask

   task automatic sendChunk(input logic [CHUNK_W-1:0] data, input bit fin);
      @(negedge iCLK);
      iDATA   = data;
      iFINISH = fin;
      iNEXT   = 1'b1;
      modelChunk(data, fin);
      @(negedge iCLK);
      checkEq("start_pulse", oSTART, fin);
      checkEq("err_after_chunk", oERR, refErr);
      iNEXT = 1'b0;
   endtask

   // Walks the frame beat by beat; re-checks the same beat on every stalled cycle.
   task automatic streamFrame(input bit randReady, input int injectAt, input int abortAt);
      int  b = 0;
      int  cyc = 0;
      bit  done = 1'b0;
      while (!done && cyc < 3000) begin
         @(negedge iCLK);
         cyc++;
         if (b == abortAt) begin
            iRESETn = 1'b0;
            #1;
            checkEq("reset_outputs", {oPIXELS, oPIX_VALID, oLAST, oSTART, oBUSY, oERR}, '0);
            modelReset();
            iNEXT  = 1'b0;
            iREADY = 1'b0;
            repeat (2) @(negedge iCLK);
            iRESETn = 1'b1;
            @(negedge iCLK);
            checkEq("idle_after_abort", {oPIX_VALID, oSTART, oBUSY}, '0);
            return;
         end
         checkEq("pix_valid", oPIX_VALID, 1'b1);
         checkEq("busy", oBUSY, 1'b1);
         checkEq($sformatf("pixels_b%0d", b), oPIXELS, expPix(b));
         checkEq($sformatf("last_b%0d", b), oLAST, (b == NB - 1));
         streamBits[b*PIX_W +: PIX_W] = oPIXELS;
         if (b == injectAt) begin
            iDATA  = randChunk();
            iNEXT  = 1'b1;
            refErr = 1'b1;
         end else begin
            iNEXT = 1'b0;
         end
         iREADY = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (iREADY) begin
            if (b == NB - 1) done = 1'b1;
            b++;
         end
      end
      if (!done) checkEq("stream_timeout", 0, 1);
      @(negedge iCLK);
      checkEq("busy_fall", oBUSY, 1'b0);
      checkEq("err_after_frame", oERR, refErr);
      iREADY = 1'b0;
      iNEXT  = 1'b0;
   endtask

   initial begin
      modelReset();
      repeat (3) @(negedge iCLK);
      checkEq("reset_state", {oPIXELS, oPIX_VALID, oLAST, oSTART, oBUSY, oERR}, '0);
      iRESETn = 1'b1;

      for (int i = 0; i < WORDS; i++) begin
         c0[i*WORD_W +: WORD_W] = 32'hA5A5_0000 + i;
         c1[i*WORD_W +: WORD_W] = 32'h5A5A_0000 + i;
      end

      // two-chunk frame, ready held high
      sendChunk(c0, 1'b0);
      sendChunk(c1, 1'b1);
      streamFrame(1'b0, -1, -1);
      checkEq("frame_concat", streamBits, {5'b0, c1[351:0], c0});

      // random data under backpressure
      sendChunk(randChunk(), 1'b0);
      sendChunk(randChunk(), 1'b1);
      streamFrame(1'b1, -1, -1);

      // single-chunk frame: the upper bits keep the previous frame
      sendChunk(randChunk(), 1'b1);
      streamFrame(1'b1, -1, -1);

      // NEXT held high for 20 cycles counts once
      @(negedge iCLK);
      iDATA   = randChunk();
      iFINISH = 1'b0;
      iNEXT   = 1'b1;
      modelChunk(iDATA, 1'b0);
      repeat (20) @(negedge iCLK);
      checkEq("held_next_err", oERR, 1'b0);
      checkEq("held_next_start", oSTART, 1'b0);
      iNEXT = 1'b0;
      sendChunk(randChunk(), 1'b1);
      streamFrame(1'b1, -1, -1);

      // NEXT rising mid-stream
      sendChunk(randChunk(), 1'b0);
      sendChunk(randChunk(), 1'b1);
      streamFrame(1'b1, 40, -1);
      checkEq("inject_err_sticky", oERR, 1'b1);

      // overflow
      applyReset();
      checkEq("err_cleared", oERR, 1'b0);
      sendChunk(randChunk(), 1'b0);
      sendChunk(randChunk(), 1'b0);
      sendChunk(randChunk(), 1'b0);
      checkEq("overflow_err", oERR, 1'b1);
      sendChunk(randChunk(), 1'b1);
      streamFrame(1'b1, -1, -1);

      // reset at beat 50, then a fresh frame
      applyReset();
      sendChunk(randChunk(), 1'b0);
      sendChunk(randChunk(), 1'b1);
      streamFrame(1'b0, -1, 50);
      sendChunk(c0, 1'b0);
      sendChunk(c1, 1'b1);
      streamFrame(1'b1, -1, -1);
      checkEq("frame_concat_after_reset", streamBits, {5'b0, c1[351:0], c0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
